// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, holds the fetched word for decode,
// redirects on a taken beq. Optional stall counter enabled by FETCH_STALL_CNT_EN.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instru,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              SaltoCond,
    input  logic              Cero,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [1:0] {
        S_REQ_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] br_off;
    logic              capture;
    logic              accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_REQ_IDLE;
            pc     <= RESET_PC;
            instru <= 32'h0;
            pc_out <= RESET_PC;
        end else begin
            state <= state_nx;
            if (capture) begin
                instru <= imem_rdata;
                pc_out <= pc;
            end
            if (accept) begin
                pc <= next_pc;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        accept      = 1'b0;
        case (state)
            S_REQ_IDLE: begin
                state_nx = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    capture  = 1'b1;
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    accept   = 1'b1;
                    state_nx = S_REQ;
                end
            end
            default: begin
                state_nx = S_REQ_IDLE;
            end
        endcase
    end

    // Branch displacement is a signed word offset relative to the instruction after the branch.
    always_comb begin
        br_off  = {{(ADDR_W-18){instru[15]}}, instru[15:0], 2'b00};
        next_pc = pc_out + ADDR_W'(4);
        if (SaltoCond && Cero) begin
            next_pc = pc_out + ADDR_W'(4) + br_off;
        end
    end

    assign imem_addr = {pc[ADDR_W-1:2], 2'b00};

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stall_cond;

    assign stall_cond = ((state == S_REQ) && !imem_ack) ||
                        ((state == S_HOLD) && !instr_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'h0;
        end else if (stall_cond && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table for the fetch/branch/reset corners, then
// randomized memory/decode handshakes against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instru;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;
    logic        SaltoCond;
    logic        Cero;
    logic [31:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instru     (instru),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_out     (pc_out),
        .SaltoCond  (SaltoCond),
        .Cero       (Cero),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        salto;
        logic        cero;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInstru;
        logic [31:0] expPcOut;
    } vec_t;

    vec_t vecs[$];

    // Transaction-level model: where the next fetch goes, what is being presented, how many
    // cycles were lost waiting on memory or decode.
    logic        mAwaitingMem;
    logic        mPresenting;
    logic [31:0] mNextFetch;
    logic [31:0] mInstru;
    logic [31:0] mPcOut;
    logic [31:0] mStall;

    task automatic addVec(input logic r, input logic a, input logic [31:0] d, input logic rdy,
                          input logic s, input logic c, input logic eReq, input logic [31:0] eAddr,
                          input logic eValid, input logic [31:0] eInstru, input logic [31:0] ePc);
        vec_t v;
        v.rst = r; v.ack = a; v.rdata = d; v.ready = rdy; v.salto = s; v.cero = c;
        v.expReq = eReq; v.expAddr = eAddr; v.expValid = eValid;
        v.expInstru = eInstru; v.expPcOut = ePc;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic modelStep(input logic r, input logic a, input logic [31:0] d,
                             input logic rdy, input logic s, input logic c);
        logic signed [15:0] imm;
        int                 disp;
        if (r) begin
            mAwaitingMem = 1'b0;
            mPresenting  = 1'b0;
            mNextFetch   = 32'h0;
            mInstru      = 32'h0;
            mPcOut       = 32'h0;
            mStall       = 32'h0;
        end else if (!mAwaitingMem && !mPresenting) begin
            mAwaitingMem = 1'b1;
        end else if (mAwaitingMem) begin
            if (a) begin
                mInstru      = d;
                mPcOut       = mNextFetch;
                mAwaitingMem = 1'b0;
                mPresenting  = 1'b1;
            end else begin
                bumpStall();
            end
        end else begin
            if (rdy) begin
                imm  = mInstru[15:0];
                disp = (s && c) ? int'(imm) * 4 : 0;
                mNextFetch   = mPcOut + 32'd4 + 32'(disp);
                mPresenting  = 1'b0;
                mAwaitingMem = 1'b1;
            end else begin
                bumpStall();
            end
        end
    endtask

    task automatic bumpStall();
`ifdef FETCH_STALL_CNT_EN
        if (mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
`endif
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic [31:0] d,
                                 input logic rdy, input logic s, input logic c);
        rst         = r;
        imem_ack    = a;
        imem_rdata  = d;
        instr_ready = rdy;
        SaltoCond   = s;
        Cero        = c;
        @(posedge clk);
        #1;
        modelStep(r, a, d, rdy, s, c);
        checkOutput("stall_cnt", stall_cnt, mStall);
    endtask

    task automatic checkAgainstModel();
        checkOutput("rnd_imem_req", 32'(imem_req), 32'(mAwaitingMem));
        checkOutput("rnd_imem_addr", imem_addr, mNextFetch);
        checkOutput("rnd_instr_valid", 32'(instr_valid), 32'(mPresenting));
        checkOutput("rnd_instru", instru, mInstru);
        checkOutput("rnd_pc_out", pc_out, mPcOut);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; SaltoCond = 1'b0; Cero = 1'b0;
        mAwaitingMem = 1'b0; mPresenting = 1'b0; mNextFetch = 32'h0;
        mInstru = 32'h0; mPcOut = 32'h0; mStall = 32'h0;

        //     rst ack rdata          rdy s  c  | req addr          vld instru         pc_out
        addVec(1, 0, 32'h0,          0, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0);
        addVec(0, 0, 32'h0,          1, 0, 0,   1, 32'h0,         0, 32'h0,         32'h0);
        addVec(0, 1, 32'hA000_0000,  1, 0, 0,   0, 32'h0,         1, 32'hA000_0000, 32'h0);
        addVec(0, 0, 32'h0,          1, 0, 0,   1, 32'h4,         0, 32'hA000_0000, 32'h0);
        addVec(0, 1, 32'hA000_0001,  1, 0, 0,   0, 32'h4,         1, 32'hA000_0001, 32'h4);
        addVec(0, 0, 32'h0,          1, 0, 0,   1, 32'h8,         0, 32'hA000_0001, 32'h4);
        addVec(0, 1, 32'hA000_0002,  1, 0, 0,   0, 32'h8,         1, 32'hA000_0002, 32'h8);
        addVec(0, 0, 32'h0,          1, 0, 0,   1, 32'hC,         0, 32'hA000_0002, 32'h8);
        // memory holds off the ack for three cycles
        addVec(0, 0, 32'h0,          0, 0, 0,   1, 32'hC,         0, 32'hA000_0002, 32'h8);
        addVec(0, 0, 32'h0,          0, 0, 0,   1, 32'hC,         0, 32'hA000_0002, 32'h8);
        addVec(0, 0, 32'h0,          0, 0, 0,   1, 32'hC,         0, 32'hA000_0002, 32'h8);
        addVec(0, 1, 32'hA000_0003,  0, 0, 0,   0, 32'hC,         1, 32'hA000_0003, 32'hC);
        // decode backpressure; branch inputs and a stray ack must be ignored
        addVec(0, 0, 32'h0,          0, 1, 1,   0, 32'hC,         1, 32'hA000_0003, 32'hC);
        addVec(0, 1, 32'hBAD0_BAD0,  0, 1, 1,   0, 32'hC,         1, 32'hA000_0003, 32'hC);
        addVec(0, 0, 32'h0,          0, 1, 1,   0, 32'hC,         1, 32'hA000_0003, 32'hC);
        addVec(0, 0, 32'h0,          0, 1, 1,   0, 32'hC,         1, 32'hA000_0003, 32'hC);
        addVec(0, 0, 32'h0,          1, 0, 0,   1, 32'h10,        0, 32'hA000_0003, 32'hC);
        // branch forward to 0x20, then the backward beq -1 taken / not taken
        addVec(0, 1, 32'h1000_0003,  0, 0, 0,   0, 32'h10,        1, 32'h1000_0003, 32'h10);
        addVec(0, 0, 32'h0,          1, 1, 1,   1, 32'h20,        0, 32'h1000_0003, 32'h10);
        addVec(0, 1, 32'h1000_FFFF,  0, 0, 0,   0, 32'h20,        1, 32'h1000_FFFF, 32'h20);
        addVec(0, 0, 32'h0,          1, 1, 1,   1, 32'h20,        0, 32'h1000_FFFF, 32'h20);
        addVec(0, 1, 32'h1000_FFFF,  0, 0, 0,   0, 32'h20,        1, 32'h1000_FFFF, 32'h20);
        addVec(0, 0, 32'h0,          1, 1, 0,   1, 32'h24,        0, 32'h1000_FFFF, 32'h20);
        // branch back to 0xFFFF_FFF8, then forward branch that wraps to 0
        addVec(0, 1, 32'h1000_FFF4,  0, 0, 0,   0, 32'h24,        1, 32'h1000_FFF4, 32'h24);
        addVec(0, 0, 32'h0,          1, 1, 1,   1, 32'hFFFF_FFF8, 0, 32'h1000_FFF4, 32'h24);
        addVec(0, 1, 32'h1000_0001,  0, 0, 0,   0, 32'hFFFF_FFF8, 1, 32'h1000_0001, 32'hFFFF_FFF8);
        addVec(0, 0, 32'h0,          1, 1, 1,   1, 32'h0,         0, 32'h1000_0001, 32'hFFFF_FFF8);
        // reach 0xFFFF_FFFC, then sequential wrap
        addVec(0, 1, 32'h1000_FFFE,  0, 0, 0,   0, 32'h0,         1, 32'h1000_FFFE, 32'h0);
        addVec(0, 0, 32'h0,          1, 1, 1,   1, 32'hFFFF_FFFC, 0, 32'h1000_FFFE, 32'h0);
        addVec(0, 1, 32'hAAAA_0000,  0, 0, 0,   0, 32'hFFFF_FFFC, 1, 32'hAAAA_0000, 32'hFFFF_FFFC);
        addVec(0, 0, 32'h0,          1, 0, 0,   1, 32'h0,         0, 32'hAAAA_0000, 32'hFFFF_FFFC);
        addVec(0, 1, 32'h5555_0000,  0, 0, 0,   0, 32'h0,         1, 32'h5555_0000, 32'h0);
        addVec(0, 0, 32'h0,          1, 0, 0,   1, 32'h4,         0, 32'h5555_0000, 32'h0);
        // reset collides with an ack, then a late ack while idle
        addVec(1, 1, 32'hDEAD_BEEF,  0, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0);
        addVec(0, 1, 32'hBEEF_CAFE,  0, 0, 0,   1, 32'h0,         0, 32'h0,         32'h0);
        addVec(0, 0, 32'h0,          0, 0, 0,   1, 32'h0,         0, 32'h0,         32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].ack, vecs[i].rdata,
                          vecs[i].ready, vecs[i].salto, vecs[i].cero);
            checkOutput($sformatf("v%0d_imem_req", i), 32'(imem_req), 32'(vecs[i].expReq));
            checkOutput($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].expAddr);
            checkOutput($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("v%0d_instru", i), instru, vecs[i].expInstru);
            checkOutput($sformatf("v%0d_pc_out", i), pc_out, vecs[i].expPcOut);
        end

        for (int n = 0; n < 800; n++) begin
            logic        r;
            logic        a;
            logic [31:0] d;
            r = ($urandom_range(0, 59) == 0);
            a = ($urandom_range(0, 9) < 4);
            d = $urandom;
            applyStimulus(r, a, d, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkAgainstModel();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
